// File: rtl/mips_exec_unit_if.sv
// Datapath bundle between the fetch/register-file side and mips_exec_unit.
// The master supplies the instruction and operands; the slave returns control and results.
interface mips_exec_unit_if;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        reg_dst;
  logic        reg_write;
  logic        alu_src;
  logic        mem_read;
  logic        mem_write;
  logic        npc_jmp;
  logic [3:0]  alu_ctl;
  logic [4:0]  wr_addr;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic [31:0] wb_data;

  modport master (
    output instr, rs_data, rt_data,
    input  reg_dst, reg_write, alu_src, mem_read, mem_write, npc_jmp,
    input  alu_ctl, wr_addr, alu_out, alu_zero, wb_data
  );

  modport slave (
    input  instr, rs_data, rt_data,
    output reg_dst, reg_write, alu_src, mem_read, mem_write, npc_jmp,
    output alu_ctl, wr_addr, alu_out, alu_zero, wb_data
  );
endinterface

// File: rtl/mips_exec_unit.sv
// Single-cycle MIPS-lite execution core: decode, 32-bit ALU and word-addressed data memory.
// Optional feature macro: ALU_SLT_EN adds the slt instruction and the SLT ALU operation.
module mips_exec_unit #(
  parameter int DM_WORDS = 64
) (
  input logic             clk,
  input logic             rst,
  mips_exec_unit_if.slave bus
);

  localparam int AW = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_LUI = 4'b1000;

  logic [5:0]  op_s;
  logic [5:0]  funct_s;
  logic [15:0] imm_s;
  logic [31:0] ext_imm_s;
  logic [31:0] alu_b_s;
  logic [31:0] alu_out_s;
  logic        reg_dst_s;
  logic        reg_write_s;
  logic        alu_src_s;
  logic        mem_read_s;
  logic        mem_write_s;
  logic        beq_s;
  logic        sign_ext_s;
  logic [3:0]  alu_ctl_s;
  logic [AW-1:0] dm_idx_s;
  logic [31:0] dm_rdata_s;
  logic [31:0] mem_r [DM_WORDS];
  logic        unused_s;

  assign op_s    = bus.instr[31:26];
  assign funct_s = bus.instr[5:0];
  assign imm_s   = bus.instr[15:0];
  assign unused_s = ^bus.instr[25:21];

  // Instruction decode: unknown op/funct falls through to an all-zero-strobe NOP.
  always_comb begin
    reg_dst_s   = 1'b0;
    reg_write_s = 1'b0;
    alu_src_s   = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    beq_s       = 1'b0;
    sign_ext_s  = 1'b0;
    alu_ctl_s   = ALU_ADD;
    case (op_s)
      6'b000000: begin
        case (funct_s)
          6'b100001: begin
            reg_dst_s   = 1'b1;
            reg_write_s = 1'b1;
            alu_ctl_s   = ALU_ADD;
          end
          6'b100011: begin
            reg_dst_s   = 1'b1;
            reg_write_s = 1'b1;
            alu_ctl_s   = ALU_SUB;
          end
`ifdef ALU_SLT_EN
          6'b101010: begin
            reg_dst_s   = 1'b1;
            reg_write_s = 1'b1;
            alu_ctl_s   = ALU_SLT;
          end
`endif
          default: alu_ctl_s = ALU_ADD;
        endcase
      end
      6'b001101: begin
        reg_write_s = 1'b1;
        alu_src_s   = 1'b1;
        alu_ctl_s   = ALU_OR;
      end
      6'b001111: begin
        reg_write_s = 1'b1;
        alu_src_s   = 1'b1;
        alu_ctl_s   = ALU_LUI;
      end
      6'b100011: begin
        reg_write_s = 1'b1;
        alu_src_s   = 1'b1;
        mem_read_s  = 1'b1;
        sign_ext_s  = 1'b1;
        alu_ctl_s   = ALU_ADD;
      end
      6'b101011: begin
        alu_src_s   = 1'b1;
        mem_write_s = 1'b1;
        sign_ext_s  = 1'b1;
        alu_ctl_s   = ALU_ADD;
      end
      6'b000100: begin
        beq_s     = 1'b1;
        alu_ctl_s = ALU_SUB;
      end
      default: alu_ctl_s = ALU_ADD;
    endcase
  end

  assign ext_imm_s = sign_ext_s ? {{16{imm_s[15]}}, imm_s} : {16'h0000, imm_s};
  assign alu_b_s   = alu_src_s ? ext_imm_s : bus.rt_data;

  // ALU; unassigned codes (and SLT when the feature is off) give zero.
  always_comb begin
    alu_out_s = 32'h0000_0000;
    case (alu_ctl_s)
      ALU_AND: alu_out_s = bus.rs_data & alu_b_s;
      ALU_OR:  alu_out_s = bus.rs_data | alu_b_s;
      ALU_ADD: alu_out_s = bus.rs_data + alu_b_s;
      ALU_SUB: alu_out_s = bus.rs_data - alu_b_s;
`ifdef ALU_SLT_EN
      ALU_SLT: alu_out_s = ($signed(bus.rs_data) < $signed(alu_b_s)) ? 32'h0000_0001 : 32'h0000_0000;
`endif
      ALU_LUI: alu_out_s = {alu_b_s[15:0], 16'h0000};
      default: alu_out_s = 32'h0000_0000;
    endcase
  end

  // Byte address bits [1:0] and everything above bit 7 are dropped, so addresses alias.
  assign dm_idx_s   = alu_out_s[AW+1:2];
  assign dm_rdata_s = mem_read_s ? mem_r[dm_idx_s] : 32'h0000_0000;

  // Data memory: asynchronous clear while in reset, store on the rising edge otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (mem_write_s) begin
      mem_r[dm_idx_s] <= bus.rt_data;
    end
  end

  assign bus.reg_dst   = reg_dst_s;
  assign bus.reg_write = reg_write_s;
  assign bus.alu_src   = alu_src_s;
  assign bus.mem_read  = mem_read_s;
  assign bus.mem_write = mem_write_s;
  assign bus.npc_jmp   = beq_s & (alu_out_s == 32'h0000_0000);
  assign bus.alu_ctl   = alu_ctl_s;
  assign bus.wr_addr   = reg_dst_s ? bus.instr[15:11] : bus.instr[20:16];
  assign bus.alu_out   = alu_out_s;
  assign bus.alu_zero  = (alu_out_s == 32'h0000_0000);
  assign bus.wb_data   = mem_read_s ? dm_rdata_s : alu_out_s;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Self-checking bench for mips_exec_unit: vector table plus hand-written memory/reset sequences,
// with expected results queued when driven and popped when sampled on the falling edge.
module tb_mips_exec_unit;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [5:0]  ctl;   // {reg_dst, reg_write, alu_src, mem_read, mem_write, npc_jmp}
    logic [3:0]  actl;
    logic [4:0]  wa;
    logic [31:0] aout;
    logic        zero;
    logic [31:0] wb;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t exp_q[$];
  vec_t tbl[$];

  mips_exec_unit_if bus ();

  mips_exec_unit #(.DM_WORDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_op(logic [5:0] funct, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] i_op(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic vec_t mk(string n, logic [31:0] i, logic [31:0] rs, logic [31:0] rt,
                              logic [5:0] ctl, logic [3:0] ac, logic [4:0] wa,
                              logic [31:0] ao, logic z, logic [31:0] wb);
    vec_t v;
    v.name = n; v.instr = i; v.rs = rs; v.rt = rt; v.ctl = ctl; v.actl = ac;
    v.wa = wa; v.aout = ao; v.zero = z; v.wb = wb;
    return v;
  endfunction

  task automatic cmp(string nm, string fld, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, expv);
    end
  endtask

  task automatic drive(vec_t v);
    bus.instr   = v.instr;
    bus.rs_data = v.rs;
    bus.rt_data = v.rt;
    exp_q.push_back(v);
  endtask

  task automatic check();
    vec_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = exp_q.pop_front();
      cmp(e.name, "ctl", {26'h0, bus.reg_dst, bus.reg_write, bus.alu_src,
                          bus.mem_read, bus.mem_write, bus.npc_jmp}, {26'h0, e.ctl});
      cmp(e.name, "alu_ctl", {28'h0, bus.alu_ctl}, {28'h0, e.actl});
      cmp(e.name, "wr_addr", {27'h0, bus.wr_addr}, {27'h0, e.wa});
      cmp(e.name, "alu_out", bus.alu_out, e.aout);
      cmp(e.name, "alu_zero", {31'h0, bus.alu_zero}, {31'h0, e.zero});
      cmp(e.name, "wb_data", bus.wb_data, e.wb);
    end
  endtask

  // One instruction per cycle: driven just after the rising edge, checked on the falling edge.
  task automatic apply(vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;

    tbl.push_back(mk("addu", r_op(6'h21, 5'd1, 5'd2, 5'd3), 32'h0000_0005, 32'hFFFF_FFFF,
                     6'b110000, 4'b0010, 5'd3, 32'h0000_0004, 1'b0, 32'h0000_0004));
    tbl.push_back(mk("subu_eq", r_op(6'h23, 5'd1, 5'd2, 5'd7), 32'h0000_0005, 32'h0000_0005,
                     6'b110000, 4'b0110, 5'd7, 32'h0000_0000, 1'b1, 32'h0000_0000));
    tbl.push_back(mk("subu_wrap", r_op(6'h23, 5'd1, 5'd2, 5'd8), 32'h0000_0003, 32'h0000_0005,
                     6'b110000, 4'b0110, 5'd8, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFE));
    tbl.push_back(mk("ori", i_op(6'h0D, 5'd1, 5'd4, 16'h8001), 32'h1234_0000, 32'h5555_5555,
                     6'b011000, 4'b0001, 5'd4, 32'h1234_8001, 1'b0, 32'h1234_8001));
    tbl.push_back(mk("lui", i_op(6'h0F, 5'd1, 5'd9, 16'hABCD), 32'hFFFF_FFFF, 32'h0000_0001,
                     6'b011000, 4'b1000, 5'd9, 32'hABCD_0000, 1'b0, 32'hABCD_0000));
    tbl.push_back(mk("beq_taken", i_op(6'h04, 5'd1, 5'd5, 16'h0010), 32'h0000_0007, 32'h0000_0007,
                     6'b000001, 4'b0110, 5'd5, 32'h0000_0000, 1'b1, 32'h0000_0000));
    tbl.push_back(mk("beq_not", i_op(6'h04, 5'd1, 5'd5, 16'h0010), 32'h0000_0007, 32'h0000_0008,
                     6'b000000, 4'b0110, 5'd5, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF));
    tbl.push_back(mk("undef_op", i_op(6'h3F, 5'd1, 5'd2, 16'h0010), 32'h0000_0005, 32'h0000_0006,
                     6'b000000, 4'b0010, 5'd2, 32'h0000_000B, 1'b0, 32'h0000_000B));
    tbl.push_back(mk("undef_funct", r_op(6'h00, 5'd1, 5'd2, 5'd3), 32'h0000_0001, 32'h0000_0002,
                     6'b000000, 4'b0010, 5'd2, 32'h0000_0003, 1'b0, 32'h0000_0003));
`ifdef ALU_SLT_EN
    tbl.push_back(mk("slt", r_op(6'h2A, 5'd1, 5'd2, 5'd10), 32'hFFFF_FFFF, 32'h0000_0001,
                     6'b110000, 4'b0111, 5'd10, 32'h0000_0001, 1'b0, 32'h0000_0001));
`else
    tbl.push_back(mk("slt_nop", r_op(6'h2A, 5'd1, 5'd2, 5'd10), 32'hFFFF_FFFF, 32'h0000_0001,
                     6'b000000, 4'b0010, 5'd2, 32'h0000_0000, 1'b1, 32'h0000_0000));
`endif

    // Combinational outputs follow instr even in reset; memory reads as zero.
    #1;
    drive(mk("lw_in_reset", i_op(6'h23, 5'd1, 5'd2, 16'hFFFC), 32'h0000_0020, 32'h0000_0000,
             6'b011100, 4'b0010, 5'd2, 32'h0000_001C, 1'b0, 32'h0000_0000));
    @(negedge clk);
    check();
    #2 rst = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Store then load; the load before the store's edge sees the old zero.
    apply(mk("lw_before_sw", i_op(6'h23, 5'd1, 5'd6, 16'h0004), 32'h0000_0010, 32'h0000_0000,
             6'b011100, 4'b0010, 5'd6, 32'h0000_0014, 1'b0, 32'h0000_0000));
    apply(mk("sw", i_op(6'h2B, 5'd1, 5'd6, 16'h0004), 32'h0000_0010, 32'hDEAD_BEEF,
             6'b001010, 4'b0010, 5'd6, 32'h0000_0014, 1'b0, 32'h0000_0014));
    apply(mk("lw_after_sw", i_op(6'h23, 5'd1, 5'd6, 16'h0004), 32'h0000_0010, 32'h0000_0000,
             6'b011100, 4'b0010, 5'd6, 32'h0000_0014, 1'b0, 32'hDEAD_BEEF));
    apply(mk("sw_word7", i_op(6'h2B, 5'd1, 5'd3, 16'h0000), 32'h0000_001C, 32'h0BAD_F00D,
             6'b001010, 4'b0010, 5'd3, 32'h0000_001C, 1'b0, 32'h0000_001C));
    apply(mk("lw_neg_off", i_op(6'h23, 5'd1, 5'd3, 16'hFFFC), 32'h0000_0020, 32'h0000_0000,
             6'b011100, 4'b0010, 5'd3, 32'h0000_001C, 1'b0, 32'h0BAD_F00D));
    apply(mk("sw_word1", i_op(6'h2B, 5'd1, 5'd4, 16'h0000), 32'h0000_0004, 32'h55AA_1234,
             6'b001010, 4'b0010, 5'd4, 32'h0000_0004, 1'b0, 32'h0000_0004));
    apply(mk("lw_alias", i_op(6'h23, 5'd1, 5'd4, 16'h0004), 32'h0000_0100, 32'h0000_0000,
             6'b011100, 4'b0010, 5'd4, 32'h0000_0104, 1'b0, 32'h55AA_1234));
    apply(mk("lw_unaligned", i_op(6'h23, 5'd1, 5'd4, 16'h0003), 32'h0000_0014, 32'h0000_0000,
             6'b011100, 4'b0010, 5'd4, 32'h0000_0017, 1'b0, 32'hDEAD_BEEF));

    // Mid-cycle reset clears memory at once; a store during reset is dropped.
    @(posedge clk);
    #1;
    drive(mk("lw_reset_mid", i_op(6'h23, 5'd1, 5'd6, 16'h0004), 32'h0000_0010, 32'h0000_0000,
             6'b011100, 4'b0010, 5'd6, 32'h0000_0014, 1'b0, 32'h0000_0000));
    #2 rst = 1'b0;
    @(negedge clk);
    check();
    apply(mk("sw_in_reset", i_op(6'h2B, 5'd1, 5'd6, 16'h0004), 32'h0000_0010, 32'h1234_5678,
             6'b001010, 4'b0010, 5'd6, 32'h0000_0014, 1'b0, 32'h0000_0014));
    @(posedge clk);
    #1;
    drive(mk("lw_after_rst", i_op(6'h23, 5'd1, 5'd6, 16'h0004), 32'h0000_0010, 32'h0000_0000,
             6'b011100, 4'b0010, 5'd6, 32'h0000_0014, 1'b0, 32'h0000_0000));
    #2 rst = 1'b1;
    @(negedge clk);
    check();
    apply(mk("lw_word1_clr", i_op(6'h23, 5'd1, 5'd4, 16'h0004), 32'h0000_0000, 32'h0000_0000,
             6'b011100, 4'b0010, 5'd4, 32'h0000_0004, 1'b0, 32'h0000_0000));
    apply(mk("sw_post_rst", i_op(6'h2B, 5'd1, 5'd2, 16'h0008), 32'h0000_0000, 32'hCAFE_0001,
             6'b001010, 4'b0010, 5'd2, 32'h0000_0008, 1'b0, 32'h0000_0008));
    apply(mk("lw_post_rst", i_op(6'h23, 5'd1, 5'd2, 16'h0008), 32'h0000_0000, 32'h0000_0000,
             6'b011100, 4'b0010, 5'd2, 32'h0000_0008, 1'b0, 32'hCAFE_0001));

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
